serial_word_comparator: RTL and testbench

//  Multi-cycle magnitude comparator for WIDTH-bit unsigned words.

---
 rtl/cmp_pkg.sv | 14 +
 rtl/cmp2_slice.sv | 15 +
 rtl/serial_word_comparator.sv | 90 +++++++++
 tb/tb_serial_word_comparator.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// cmp_pkg: shared state encodings, one-hot result constants and slice width
// for the serial word comparator.
package cmp_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
    localparam int SLICE_W = 2;
    // Result vectors are ordered {G, E, L}.
    localparam logic [2:0] RES_G = 3'b100;
    localparam logic [2:0] RES_E = 3'b010;
    localparam logic [2:0] RES_L = 3'b001;
endpackage

// File: rtl/cmp2_slice.sv
// cmp2_slice: gate-level 2-bit unsigned magnitude comparator producing G/E/L.
module cmp2_slice (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       G,
    output logic       E,
    output logic       L
);
    logic hi_eq, lo_eq;
    assign hi_eq = ~(a[1] ^ b[1]);
    assign lo_eq = ~(a[0] ^ b[0]);
    assign G = (a[1] & ~b[1]) | (hi_eq & a[0] & ~b[0]);
    assign L = (~a[1] & b[1]) | (hi_eq & ~a[0] & b[0]);
    assign E = hi_eq & lo_eq;
endmodule

// File: rtl/serial_word_comparator.sv
// serial_word_comparator: MSB-first multi-cycle unsigned compare, one 2-bit slice per clock.
// Define SERIAL_CMP_EARLY_EXIT_EN to finish at the first unequal slice.
module serial_word_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             G,
    output logic             E,
    output logic             L
);
    localparam int NS = WIDTH / SLICE_W;
    localparam int IW = NS > 1 ? $clog2(NS) : 1;

    state_t               state, state_n;
    logic [WIDTH-1:0]     ra, rb;
    logic [IW-1:0]        idx;
    logic [SLICE_W-1:0]   sa, sb;
    logic                 sg, sl, cg, ce, cl, fg, fl, fin, accept;
    logic [2:0]           res;

    assign sa = ra[int'(idx) * SLICE_W +: SLICE_W];
    assign sb = rb[int'(idx) * SLICE_W +: SLICE_W];

    cmp2_slice u_slice (
        .a(sa),
        .b(sb),
        .G(cg),
        .E(ce),
        .L(cl)
    );

    assign accept = start && state != ST_CMP;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    assign fin = idx == '0 || !ce;
`else
    assign fin = idx == '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = accept ? ST_CMP : state == ST_CMP ? (fin ? ST_DONE : ST_CMP) : ST_IDLE;
    end

    always_comb begin
        busy = state == ST_CMP;
        done = state == ST_DONE;
    end

    // The first unequal slice decides; later slices cannot override it.
    always_comb begin
        fg = sg | (!sl & cg);
        fl = sl | (!sg & cl);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ra  <= '0;
            rb  <= '0;
            idx <= '0;
            sg  <= 1'b0;
            sl  <= 1'b0;
            res <= '0;
        end else if (accept) begin
            ra  <= a;
            rb  <= b;
            idx <= IW'(NS - 1);
            sg  <= 1'b0;
            sl  <= 1'b0;
        end else if (state == ST_CMP) begin
            idx <= idx == '0 ? idx : idx - 1'b1;
            sg  <= fg;
            sl  <= fl;
            if (fin) res <= fg ? RES_G : fl ? RES_L : RES_E;
        end
    end

    assign {G, E, L} = res;
endmodule

// File: tb/tb_serial_word_comparator.sv
// tb_serial_word_comparator: directed plus randomized checks against a
// word-level reference (plain unsigned compare, first differing slice).
module tb_serial_word_comparator;
    localparam int WIDTH = 8;
    localparam int NS = WIDTH / 2;

    logic             clk, rst, start;
    logic [WIDTH-1:0] a, b;
    logic             busy, done, G, E, L;
    logic [2:0]       gel;
    logic [2:0]       last_res;
    int               checks, failures;

    serial_word_comparator #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .G(G), .E(E), .L(L)
    );

    assign gel = {G, E, L};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] ref_res(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        return x > y ? 3'b100 : x == y ? 3'b010 : 3'b001;
    endfunction

    function automatic int ref_lat(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        for (int p = 0; p < NS; p++)
            if (((x >> (2 * (NS - 1 - p))) & 8'h3) != ((y >> (2 * (NS - 1 - p))) & 8'h3))
                return p + 1;
`endif
        return NS;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Called just after a negedge; returns at the negedge of the DONE cycle.
    task automatic run(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tbv,
                       input int pulse_j, input string tag);
        int lat;
        logic [2:0] exp_r;
        lat   = ref_lat(ta, tbv);
        exp_r = ref_res(ta, tbv);
        start = 1'b1;
        a     = ta;
        b     = tbv;
        @(posedge clk);
        for (int j = 0; j <= lat; j++) begin
            @(negedge clk);
            chk({tag, "_busy"}, busy, j < lat);
            chk({tag, "_done"}, done, j == lat);
            chk({tag, "_res"}, gel, j == lat ? exp_r : last_res);
            start = j == pulse_j;
            a     = j == pulse_j ? 8'hFF : WIDTH'($urandom);
            b     = WIDTH'($urandom);
            if (j < lat) @(posedge clk);
        end
        start    = 1'b0;
        last_res = exp_r;
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk({tag, "_busy"}, busy, 0);
            chk({tag, "_done"}, done, 0);
            chk({tag, "_res"}, gel, last_res);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        checks   = 0;
        failures = 0;
        last_res = 3'b000;
        rst      = 1'b1;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_res", gel, 0);
        rst = 1'b0;
        idle(1, "idle0");

        run(8'hA5, 8'hA5, -1, "eq_a5");
        idle(1, "idle1");
        run(8'h80, 8'h7F, -1, "msb_gt");
        idle(1, "idle2");
        run(8'h03, 8'h04, -1, "s1_lt");
        idle(1, "idle3");
        run(8'h10, 8'h01, 1, "ign_start");
        idle(3, "no_extra");

        // Reset in flight: operands latched, rst sampled at t0+2.
        start = 1'b1;
        a     = 8'h00;
        b     = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("rstmid_busy0", busy, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_busy", busy, 0);
        chk("rstmid_done", done, 0);
        chk("rstmid_res", gel, 0);
        last_res = 3'b000;
        idle(NS + 2, "rstmid_after");

        run(8'hC0, 8'h40, -1, "b2b_first");
        run(8'h01, 8'h02, -1, "b2b_second");
        idle(1, "idle4");
        run(8'hFF, 8'h00, -1, "max_min");
        run(8'h00, 8'h00, -1, "zero_eq");

        for (int n = 0; n < 40; n++) begin
            ra = WIDTH'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
                default: rb = WIDTH'($urandom);
            endcase
            run(ra, rb, $urandom_range(0, 3) == 0 ? 0 : -1, "rand");
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2), "rand_idle");
        end
        idle(2, "final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
